// File: rtl/voter_plus_if.sv
// voter_plus_if
// Groups the voter lines and the tally output of voter_plus into one bundle.
//   np     [31:0] ordinary voter lines, bit i high = ordinary voter i votes now
//   vip    [7:0]  VIP voter lines, bit j high = VIP j votes now
//   vvip          VVIP voter line
//   result [7:0]  weighted total of all votes latched since the last reset
// master: the side that drives the voter lines and reads the tally.
// slave : the tally unit itself.
interface voter_plus_if;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [7:0]  result;

    modport master (
        output np,
        output vip,
        output vvip,
        input  result
    );

    modport slave (
        input  np,
        input  vip,
        input  vvip,
        output result
    );
endinterface

// File: rtl/voter_plus.sv
// voter_plus
// Weighted, vote-latching tally unit. Every rising clock edge samples 32
// ordinary, 8 VIP and 1 VVIP voter lines; any voter seen high is remembered
// as "has voted" until reset. The output is the weighted sum of the
// remembered votes (ordinary = 1, VIP = 4, VVIP = 16).
//   clk    system clock, all flags update on the rising edge
//   reset  asynchronous, active-high; clears every voted flag at once
//   bus    voter_plus_if.slave: np/vip/vvip inputs, result output
module voter_plus (
    input  logic          clk,
    input  logic          reset,
    voter_plus_if.slave   bus
);

    logic [31:0] np_v_q;
    logic [31:0] np_v_d;
    logic [7:0]  vip_v_q;
    logic [7:0]  vip_v_d;
    logic        vvip_v_q;
    logic        vvip_v_d;

    logic [5:0]  np_cnt;
    logic [3:0]  vip_cnt;

    // Votes are sticky: a flag once set stays set, so re-asserting a line
    // can never count twice and dropping it never removes the vote.
    always_comb begin
        np_v_d   = np_v_q   | bus.np;
        vip_v_d  = vip_v_q  | bus.vip;
        vvip_v_d = vvip_v_q | bus.vvip;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            np_v_q   <= '0;
            vip_v_q  <= '0;
            vvip_v_q <= 1'b0;
        end else begin
            np_v_q   <= np_v_d;
            vip_v_q  <= vip_v_d;
            vvip_v_q <= vvip_v_d;
        end
    end

    // Popcounts are taken from the flags only, so the inputs influence the
    // tally only after they have been sampled by an edge.
    always_comb begin
        np_cnt  = '0;
        vip_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            np_cnt = np_cnt + {5'b0, np_v_q[i]};
        end
        for (int j = 0; j < 8; j++) begin
            vip_cnt = vip_cnt + {3'b0, vip_v_q[j]};
        end
    end

    // Maximum is 32 + 32 + 16 = 80, so an 8-bit sum never overflows.
    // VIP weight 4 and VVIP weight 16 are plain bit shifts.
    always_comb begin
        bus.result = {2'b00, np_cnt}
                   + {2'b00, vip_cnt, 2'b00}
                   + {3'b000, vvip_v_q, 4'b0000};
    end

endmodule

// File: tb/tb_voter_plus.sv
// tb_voter_plus
// Directed bench for voter_plus. A set-based model of who has voted runs
// alongside the design and is compared with result on every falling edge;
// hand-computed tallies pin both the design and the model at key points.
module tb_voter_plus;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   cmp_en;

    voter_plus_if bus ();

    voter_plus dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: which voters have been seen voting since the last reset.
    logic [31:0] m_np;
    logic [7:0]  m_vip;
    logic        m_vvip;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_np   <= '0;
            m_vip  <= '0;
            m_vvip <= 1'b0;
        end else begin
            m_np   <= m_np | bus.np;
            m_vip  <= m_vip | bus.vip;
            m_vvip <= m_vvip | bus.vvip;
        end
    end

    function automatic int model_tally();
        return $countones(m_np) + 4 * $countones(m_vip) + 16 * int'(m_vvip);
    endfunction

    // Continuous comparison on every falling edge, away from sampling edges.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (int'(bus.result) != model_tally()) begin
                errors++;
                $display("[TB] FAIL cycle_compare t=%0t result=%0d model=%0d",
                         $time, bus.result, model_tally());
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] np, input logic [7:0] vip,
                                 input logic vvip);
        @(negedge clk);
        bus.np   = np;
        bus.vip  = vip;
        bus.vvip = vvip;
    endtask

    task automatic checkOutput(input string name, input int expected);
        checks++;
        if (int'(bus.result) != expected) begin
            errors++;
            $display("[TB] FAIL %s result=%0d expected=%0d", name, bus.result, expected);
        end
        checks++;
        if (model_tally() != expected) begin
            errors++;
            $display("[TB] FAIL model_%s model=%0d expected=%0d", name, model_tally(), expected);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #1 reset = 1'b1;
        bus.np   = '0;
        bus.vip  = '0;
        bus.vvip = 1'b0;
        #1 checkOutput("pulse_reset", 0);
        #1 reset = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        cmp_en   = 1'b0;
        reset    = 1'b0;
        bus.np   = 32'hFFFF_FFFF;
        bus.vip  = 8'hFF;
        bus.vvip = 1'b1;

        // Reset with all lines active: zero at once and while held.
        #2 reset = 1'b1;
        #1 checkOutput("reset_immediate", 0);
        cmp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("reset_hold", 0);
        end

        // Partial vote: 28 ordinary + 5 VIP.
        @(negedge clk);
        bus.np   = 32'hFFFF_FFF0;
        bus.vip  = 8'hD5;
        bus.vvip = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("partial_vote", 48);

        // Complementary lines complete every flag.
        applyStimulus(32'h0000_000F, 8'h2A, 1'b1);
        @(negedge clk);
        checkOutput("all_voted", 80);
        applyStimulus(32'h1234_5678, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("saturated_hold_a", 80);
        applyStimulus(32'h0, 8'h0, 1'b0);
        @(negedge clk);
        checkOutput("saturated_hold_b", 80);

        // Reset between edges clears before the next edge.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("reset_midrun", 0);
        bus.np   = 32'h0000_0001;
        bus.vip  = 8'h00;
        bus.vvip = 1'b0;
        @(negedge clk);
        checkOutput("reset_midrun_hold", 0);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_sample", 1);

        // Drop-out: a single-edge VIP vote stays counted, never doubles.
        pulseReset();
        applyStimulus(32'h0, 8'h01, 1'b0);
        applyStimulus(32'h0, 8'h00, 1'b0);
        checkOutput("vip_single", 4);
        @(negedge clk);
        checkOutput("vip_dropout", 4);
        applyStimulus(32'h0, 8'h01, 1'b0);
        @(negedge clk);
        checkOutput("vip_reassert", 4);

        // Sub-cycle pulse on VVIP is invisible; a held line counts 16.
        pulseReset();
        @(posedge clk);
        #1 bus.vvip = 1'b1;
        #2 bus.vvip = 1'b0;
        @(negedge clk);
        checkOutput("vvip_glitch", 0);
        @(negedge clk);
        checkOutput("vvip_glitch_later", 0);
        applyStimulus(32'h0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("vvip_held", 16);

        // Mixed classes on one edge combine into one tally: 3 + 8 + 16.
        applyStimulus(32'h8000_0003, 8'h81, 1'b0);
        @(negedge clk);
        checkOutput("mixed_edge", 3 + 8 + 16);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
